norm_sequencer: RTL and testbench
=================================

# norm_sequencer

Iterative normalization controller that shares one shift/exponent-adjust datapath between two raw-result producers: port 0 is the adder, port 1 is the multiplier. It accepts a raw sign, an 8-bit exponent and a 25-bit mantissa (bit 24 is the carry, bit 23 is the hidden one) over a valid/ready handshake. It normalizes by shifting one bit per cycle and returns a packed single-precision sign/exponent/23-bit fraction tagged with the source port. It sits between the arithmetic cores and the result writeback.

## Interface
- No parameters. Widths are fixed at 8-bit exponent and 25-bit raw mantissa.
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock domain, synchronous, active-high
- in_valid  in  2  per-port request valid (bit 0 = adder, bit 1 = multiplier)
- in_ready  out  2  per-port accept; at most one bit is high
- in_sign0 / in_sign1  in  1  raw sign, per port
- in_exp0 / in_exp1  in  8  raw biased exponent, per port
- in_mant0 / in_mant1  in  25  raw mantissa, per port
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept
- out_sign  out  1  result sign
- out_exponent  out  8  result biased exponent
- out_mantissa  out  23  result fraction (hidden bit dropped)
- out_tag  out  1  source port of the result
- out_flags  out  2  {overflow, underflow}

## Operation
- FSM states: IDLE, NORM, DONE. Reset state is IDLE.
- **IDLE**
  - Round-robin grant. If both ports are valid, grant the port not granted last.
  - `last_grant` resets to 1, so port 0 wins the first contention.
  - `in_ready[g]` = (state==IDLE) && `in_valid[g]` && grant==g. This is combinational from state and valid.
  - On handshake: load working sign, exponent, mantissa and tag; update `last_grant`; go to NORM.
- **NORM**: evaluate once per cycle, first match wins.
  - Mantissa == 0: result is sign 0, exponent 0, fraction 0, flags 0. Go to DONE.
  - Mantissa bit 24 set, exponent >= 254: overflow. Result is exponent 255, fraction 0, flags 2'b10. Go to DONE.
  - Mantissa bit 24 set, exponent < 254: shift right by 1, exponent +1, result is the shifted mantissa[22:0]. Go to DONE.
  - Mantissa bit 23 set: result is the working exponent and mantissa[22:0]. Go to DONE.
  - Exponent <= 1 and not yet normalized: underflow, flags 2'b01. Result is per Configuration. Go to DONE.
  - Otherwise: shift mantissa left by 1, exponent −1, stay in NORM.
- The sign passes through unchanged, except that a zero result forces sign 0.
- Exponent arithmetic is 8-bit unsigned. The guards above guarantee it never wraps.
- **DONE**
  - `out_*` are registered and held stable while `out_valid` is high.
  - On `out_valid && out_ready`: clear `out_valid`, go to IDLE.
  - No new request is accepted before the return to IDLE.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `out_sign` 0, `out_exponent` 0, `out_mantissa` 0, `out_tag` 0, `out_flags` 0, `last_grant` 1.
- `rst` asserted during NORM or DONE aborts the operation. No result is produced, and the FSM is in IDLE on the next cycle.
- Acceptance happens on edge E0. With k left shifts, `out_valid` rises after edge E0+k+1.
  - Already-normalized, carry, zero or overflow input: k=0.
- Shift count is bounded at k <= 23, so latency is at most 24 cycles.
- Minimum issue interval is 3 cycles (IDLE, NORM, DONE), reached with `out_ready` held high.
- `out_ready` high before `out_valid` rises is legal; the handshake completes on the first cycle `out_valid` is high.
- Simultaneous `in_valid` = 2'b11: only the granted port sees ready. The other port must hold its request stable.

## Configuration
- `NORM_FLUSH_TO_ZERO_EN` defined: an underflow result is sign 0, exponent 0, fraction 0; `out_flags` = 2'b01.
- `NORM_FLUSH_TO_ZERO_EN` undefined: an underflow result is the sign unchanged, exponent 0, and the fraction = the working mantissa[22:0] at the point the shift stopped (denormal encoding); `out_flags` = 2'b01.

## Test plan
- Port 0 sends sign 1, exp 130, mant 25'h0800000 -> 1 cycle after accept: sign 1, exp 130, frac 0, tag 0, flags 0.
- Port 1 sends exp 100, mant 25'h1000002 -> exp 101, frac 23'h000001, tag 1, latency 1. Second case: exp 254, mant 25'h1000000 -> exp 255, frac 0, flags 2'b10.
- Port 0 sends exp 50, mant 25'h0000100 -> 15 shifts, `out_valid` 16 cycles after accept, exp 35, frac 0.
- exp 5, mant 25'h0000001 -> 4 shifts, then underflow.
  - With `NORM_FLUSH_TO_ZERO_EN`: result is all zero, flags 2'b01.
  - Without it: exp 0, frac 23'h000010, flags 2'b01.
- Both ports valid continuously and `out_ready` held at 1 -> tags alternate 0,1,0,1. `in_ready` is never 2'b11. The issue interval is 3 cycles for normalized inputs.
- Zero mantissa with sign 1 -> sign 0, exp 0, frac 0. `out_ready` held low for 5 cycles -> outputs stable throughout. `rst` pulsed mid-NORM -> no `out_valid`, all outputs at reset values.

Source files
------------

// File: rtl/norm_sequencer.sv
// Shared normalization controller: round-robin between adder (port 0) and multiplier (port 1),
// one shift per cycle. Optional flush-to-zero of underflow results via NORM_FLUSH_TO_ZERO_EN.
module norm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  in_valid,
    output logic [1:0]  in_ready,
    input  logic        in_sign0,
    input  logic        in_sign1,
    input  logic [7:0]  in_exp0,
    input  logic [7:0]  in_exp1,
    input  logic [24:0] in_mant0,
    input  logic [24:0] in_mant1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exponent,
    output logic [22:0] out_mantissa,
    output logic        out_tag,
    output logic [1:0]  out_flags
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 25;
    localparam int unsigned FRAC_W = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                w_sign_q, w_sign_d;
    logic [EXP_W-1:0]    w_exp_q, w_exp_d;
    logic [MANT_W-1:0]   w_mant_q, w_mant_d;
    logic                w_tag_q, w_tag_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sign_q, out_sign_d;
    logic [EXP_W-1:0]    out_exponent_q, out_exponent_d;
    logic [FRAC_W-1:0]   out_mantissa_q, out_mantissa_d;
    logic                out_tag_q, out_tag_d;
    logic [1:0]          out_flags_q, out_flags_d;

    logic grant_c;
    logic accept_c;
    logic norm_done_c;
    logic out_hs_c;

    // Round-robin: on contention the port not granted last wins
    always_comb begin
        grant_c = last_grant_q;
        if (in_valid == 2'b11) begin
            grant_c = ~last_grant_q;
        end else if (in_valid[0]) begin
            grant_c = 1'b0;
        end else if (in_valid[1]) begin
            grant_c = 1'b1;
        end
    end

    assign accept_c    = (state_q == IDLE) && in_valid[grant_c];
    assign in_ready    = {accept_c && grant_c, accept_c && !grant_c};
    assign out_hs_c    = out_valid_q && out_ready;
    assign norm_done_c = (w_mant_q == '0) || w_mant_q[24] || w_mant_q[23] || (w_exp_q <= 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = NORM;
            NORM:    if (norm_done_c) state_d = DONE;
            DONE:    if (out_hs_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Working datapath and registered result
    always_comb begin
        last_grant_d   = last_grant_q;
        w_sign_d       = w_sign_q;
        w_exp_d        = w_exp_q;
        w_mant_d       = w_mant_q;
        w_tag_d        = w_tag_q;
        out_valid_d    = out_valid_q;
        out_sign_d     = out_sign_q;
        out_exponent_d = out_exponent_q;
        out_mantissa_d = out_mantissa_q;
        out_tag_d      = out_tag_q;
        out_flags_d    = out_flags_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    last_grant_d = grant_c;
                    w_tag_d      = grant_c;
                    w_sign_d     = grant_c ? in_sign1 : in_sign0;
                    w_exp_d      = grant_c ? in_exp1  : in_exp0;
                    w_mant_d     = grant_c ? in_mant1 : in_mant0;
                end
            end
            NORM: begin
                if (norm_done_c) begin
                    out_valid_d = 1'b1;
                    out_tag_d   = w_tag_q;
                    out_sign_d  = w_sign_q;
                    out_flags_d = 2'b00;
                end
                if (w_mant_q == '0) begin
                    out_sign_d     = 1'b0;
                    out_exponent_d = '0;
                    out_mantissa_d = '0;
                end else if (w_mant_q[24]) begin
                    if (w_exp_q >= 8'd254) begin
                        out_exponent_d = 8'd255;
                        out_mantissa_d = '0;
                        out_flags_d    = 2'b10;
                    end else begin
                        out_exponent_d = w_exp_q + 8'd1;
                        out_mantissa_d = w_mant_q[23:1];
                    end
                end else if (w_mant_q[23]) begin
                    out_exponent_d = w_exp_q;
                    out_mantissa_d = w_mant_q[22:0];
                end else if (w_exp_q <= 8'd1) begin
                    out_flags_d    = 2'b01;
                    out_exponent_d = '0;
`ifdef NORM_FLUSH_TO_ZERO_EN
                    out_sign_d     = 1'b0;
                    out_mantissa_d = '0;
`else
                    out_mantissa_d = w_mant_q[22:0];
`endif
                end else begin
                    w_mant_d = {w_mant_q[23:0], 1'b0};
                    w_exp_d  = w_exp_q - 8'd1;
                end
            end
            DONE: begin
                if (out_hs_c) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q   <= 1'b1;
            w_sign_q       <= 1'b0;
            w_exp_q        <= '0;
            w_mant_q       <= '0;
            w_tag_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sign_q     <= 1'b0;
            out_exponent_q <= '0;
            out_mantissa_q <= '0;
            out_tag_q      <= 1'b0;
            out_flags_q    <= 2'b00;
        end else begin
            last_grant_q   <= last_grant_d;
            w_sign_q       <= w_sign_d;
            w_exp_q        <= w_exp_d;
            w_mant_q       <= w_mant_d;
            w_tag_q        <= w_tag_d;
            out_valid_q    <= out_valid_d;
            out_sign_q     <= out_sign_d;
            out_exponent_q <= out_exponent_d;
            out_mantissa_q <= out_mantissa_d;
            out_tag_q      <= out_tag_d;
            out_flags_q    <= out_flags_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sign     = out_sign_q;
    assign out_exponent = out_exponent_q;
    assign out_mantissa = out_mantissa_q;
    assign out_tag      = out_tag_q;
    assign out_flags    = out_flags_q;

endmodule

// File: tb/tb_norm_sequencer.sv
// Scoreboard bench for norm_sequencer: expected results are queued at acceptance and
// checked by an output monitor (values, hold stability, latency).
module tb_norm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic        in_sign0, in_sign1;
    logic [7:0]  in_exp0, in_exp1;
    logic [24:0] in_mant0, in_mant1;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exponent;
    logic [22:0] out_mantissa;
    logic        out_tag;
    logic [1:0]  out_flags;

    always #5 clk = ~clk;

    norm_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign0     (in_sign0),
        .in_sign1     (in_sign1),
        .in_exp0      (in_exp0),
        .in_exp1      (in_exp1),
        .in_mant0     (in_mant0),
        .in_mant1     (in_mant1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exponent (out_exponent),
        .out_mantissa (out_mantissa),
        .out_tag      (out_tag),
        .out_flags    (out_flags)
    );

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic        t;
        logic [1:0]  fl;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t pend[2];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_acc   = 0;
    int   last_acc = 0;
    int   last_p   = 0;
    bit   dual     = 1'b0;
    bit   prev_v   = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Acceptance monitor: queue the expected result of whichever port handshakes
    always @(negedge clk) begin : acc_mon
        logic [1:0] hs;
        int         p;
        exp_t       e;
        hs = in_valid & in_ready;
        if (!rst && in_valid == 2'b11) chk("in_ready_not_both", {31'd0, in_ready == 2'b11}, 32'd0);
        if (hs != 2'b00) begin
            p = hs[1] ? 1 : 0;
            if (dual) begin
                if (n_acc == 0) begin
                    chk("rr_first_port", p, 0);
                end else begin
                    chk("rr_alternate", p, 1 - last_p);
                    chk("issue_interval", cyc + 1 - last_acc, 3);
                end
            end
            e = pend[p];
            e.acc = cyc + 1;
            sb.push_back(e);
            last_p   = p;
            last_acc = cyc + 1;
            n_acc++;
        end
    end

    // Output monitor: compare every cycle out_valid is high, pop on handshake
    always @(negedge clk) begin : out_mon
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                chk("out_sign", out_sign, sb[0].s);
                chk("out_exponent", out_exponent, sb[0].e);
                chk("out_mantissa", out_mantissa, sb[0].f);
                chk("out_tag", out_tag, sb[0].t);
                chk("out_flags", out_flags, sb[0].fl);
                if (!prev_v) chk("latency", cyc - sb[0].acc, sb[0].lat);
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_v = out_valid;
    end

    task automatic drive(input int p, input logic s, input logic [7:0] e, input logic [24:0] m);
        if (p == 0) begin
            in_sign0 = s; in_exp0 = e; in_mant0 = m;
        end else begin
            in_sign1 = s; in_exp1 = e; in_mant1 = m;
        end
    endtask

    task automatic set_exp(input int p, input logic s, input logic [7:0] e, input logic [22:0] f,
                           input logic [1:0] fl, input int lat);
        pend[p] = '{s, e, f, (p == 1), fl, lat, 0};
    endtask

    task automatic send(input int p, input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic rs, input logic [7:0] re, input logic [22:0] rf,
                        input logic [1:0] rfl, input int lat);
        bit got = 1'b0;
        @(posedge clk); #1;
        drive(p, s, e, m);
        set_exp(p, rs, re, rf, rfl, lat);
        in_valid[p] = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready[p]) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid[p] = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 2'b00;
        out_ready = 1'b1;
        drive(0, 1'b0, 8'd0, 25'd0);
        drive(1, 1'b0, 8'd0, 25'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 2'b00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sign", out_sign, 1'b0);
        chk("rst_out_exponent", out_exponent, 8'd0);
        chk("rst_out_mantissa", out_mantissa, 23'd0);
        chk("rst_out_tag", out_tag, 1'b0);
        chk("rst_out_flags", out_flags, 2'b00);

        // Contention: both ports valid, out_ready high
        dual = 1'b1;
        drive(0, 1'b0, 8'd127, 25'h0800000);
        set_exp(0, 1'b0, 8'd127, 23'h000000, 2'b00, 1);
        drive(1, 1'b1, 8'd128, 25'h0C00000);
        set_exp(1, 1'b1, 8'd128, 23'h400000, 2'b00, 1);
        @(posedge clk); #1 in_valid = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (n_acc >= 4) seen = 1'b1;
        end
        if (!seen) chk("rr_timeout", 32'd1, 32'd0);
        @(posedge clk); #1 in_valid = 2'b00;
        wait_drain();
        dual = 1'b0;

        // Directed vectors
        send(0, 1'b1, 8'd130, 25'h0800000, 1'b1, 8'd130, 23'h000000, 2'b00, 1);
        wait_drain();
        send(1, 1'b0, 8'd100, 25'h1000002, 1'b0, 8'd101, 23'h000001, 2'b00, 1);
        wait_drain();
        send(1, 1'b0, 8'd254, 25'h1000000, 1'b0, 8'd255, 23'h000000, 2'b10, 1);
        wait_drain();
        send(0, 1'b1, 8'd253, 25'h1FFFFFF, 1'b1, 8'd254, 23'h7FFFFF, 2'b00, 1);
        wait_drain();
        send(0, 1'b0, 8'd50, 25'h0000100, 1'b0, 8'd35, 23'h000000, 2'b00, 16);
        wait_drain();
        send(1, 1'b0, 8'd2, 25'h0400000, 1'b0, 8'd1, 23'h000000, 2'b00, 2);
        wait_drain();
`ifdef NORM_FLUSH_TO_ZERO_EN
        send(1, 1'b1, 8'd5, 25'h0000001, 1'b0, 8'd0, 23'h000000, 2'b01, 5);
`else
        send(1, 1'b1, 8'd5, 25'h0000001, 1'b1, 8'd0, 23'h000010, 2'b01, 5);
`endif
        wait_drain();

        // Zero result with back-pressure: outputs must hold while out_ready is low
        out_ready = 1'b0;
        send(0, 1'b1, 8'd77, 25'h0000000, 1'b0, 8'd0, 23'h000000, 2'b00, 1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) chk("zero_valid_timeout", 32'd1, 32'd0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();

        // Reset pulsed mid-normalization aborts the operation
        send(0, 1'b0, 8'd50, 25'h0000100, 1'b0, 8'd35, 23'h000000, 2'b00, 16);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_exponent", out_exponent, 8'd0);
        chk("abort_out_mantissa", out_mantissa, 23'd0);
        chk("abort_out_flags", out_flags, 2'b00);
        repeat (25) @(negedge clk);
        chk("abort_no_result", out_valid, 1'b0);
        send(1, 1'b0, 8'd140, 25'h0A00000, 1'b0, 8'd140, 23'h200000, 2'b00, 1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
